// File: rtl/xbus_arb.sv
// Two-master round-robin arbiter for the soft-core data bus (IDLE->ACC->WAIT->ACK).
// Optional burst locking is compiled in with `define BUS_ARB_LOCK_EN.
module xbus_arb #(
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
`ifdef BUS_ARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    output logic          bus_sel,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic          gnt_id,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t        state_r;
    logic          last_gnt_r;
    logic          xfer_we_r;
    logic [1:0]    req_s;
    logic          other_s;
    logic          win_s;
    logic          we_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;

`ifdef BUS_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic          lock_hold_r;
    logic [CW-1:0] burst_cnt_r;
    logic          regrant_s;
`endif

    // Winner selection for the next IDLE grant and the winner's request fields.
    always_comb begin
        req_s   = {m1_req, m0_req};
        other_s = ~last_gnt_r;
        if (req_s == 2'b11) begin
            win_s = other_s;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`ifdef BUS_ARB_LOCK_EN
        regrant_s = 1'b0;
        // A locked owner keeps the bus until the burst limit, then yields to a waiting peer.
        if (lock_hold_r && req_s[last_gnt_r]) begin
            if ((burst_cnt_r >= CW'(MAX_BURST)) && req_s[other_s]) begin
                win_s = other_s;
            end else begin
                win_s     = last_gnt_r;
                regrant_s = 1'b1;
            end
        end else begin
            regrant_s = 1'b0;
        end
`endif
        if (win_s) begin
            we_s    = m1_we;
            addr_s  = m1_addr;
            wdata_s = m1_wdata;
        end else begin
            we_s    = m0_we;
            addr_s  = m0_addr;
            wdata_s = m0_wdata;
        end
    end

    // Access sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= 1'b1;
            gnt_id     <= 1'b1;
            xfer_we_r  <= 1'b0;
            bus_sel    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= {AW{1'b0}};
            bus_wdata  <= {DW{1'b0}};
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= {DW{1'b0}};
            m1_rdata   <= {DW{1'b0}};
            busy       <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
            lock_hold_r <= 1'b0;
            burst_cnt_r <= {CW{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
                    lock_hold_r <= 1'b0;
`endif
                    if (req_s != 2'b00) begin
                        state_r    <= ST_ACC;
                        bus_sel    <= 1'b1;
                        bus_we     <= we_s;
                        xfer_we_r  <= we_s;
                        bus_addr   <= addr_s;
                        bus_wdata  <= wdata_s;
                        gnt_id     <= win_s;
                        last_gnt_r <= win_s;
                        busy       <= 1'b1;
`ifdef BUS_ARB_LOCK_EN
                        if (regrant_s) begin
                            if (burst_cnt_r < CW'(MAX_BURST)) begin
                                burst_cnt_r <= burst_cnt_r + CW'(1);
                            end else begin
                                burst_cnt_r <= burst_cnt_r;
                            end
                        end else begin
                            burst_cnt_r <= {CW{1'b0}};
                        end
`endif
                    end else begin
                        bus_sel <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_ACC: begin
                    state_r <= ST_WAIT;
                    bus_sel <= 1'b0;
                    bus_we  <= 1'b0;
                end
                ST_WAIT: begin
                    state_r <= ST_ACK;
                    // Read data from the synchronous memory is valid only in this cycle.
                    if (!xfer_we_r) begin
                        if (gnt_id) begin
                            m1_rdata <= bus_rdata;
                        end else begin
                            m0_rdata <= bus_rdata;
                        end
                    end else begin
                        m0_rdata <= m0_rdata;
                    end
                    m0_ack <= ~gnt_id;
                    m1_ack <= gnt_id;
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    busy    <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
                    lock_hold_r <= gnt_id ? m1_lock : m0_lock;
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                    bus_sel <= 1'b0;
                    bus_we  <= 1'b0;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
